// File: rtl/y_mul_seq.sv
// y_mul_seq: sequential shift-add unsigned multiplier (SIZE x SIZE -> 2*SIZE), optional Y_MUL_EARLY_TERM_EN
module y_mul_seq #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] z,
    output logic [SIZE-1:0] zh
);
    localparam int CW = $clog2(SIZE) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t            state_q, state_d;
    logic [2*SIZE-1:0] mcand_q, mcand_d, acc_q, acc_d, sum;
    logic [SIZE-1:0]   mplier_q, mplier_d, z_q, z_d, zh_q, zh_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d, last;
    assign busy = busy_q;
    assign done = done_q;
    assign z    = z_q;
    assign zh   = zh_q;
    // next-state, datapath step and result publication on the final RUN edge
    always_comb begin
        sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
        last     = cnt_q == CW'(SIZE - 1);
`ifdef Y_MUL_EARLY_TERM_EN
        last     = last || ((mplier_q >> 1) == '0);
`endif
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        z_d      = z_q;
        zh_d     = zh_q;
        case (state_q)
            IDLE: if (start) begin
                mcand_d  = {{SIZE{1'b0}}, a};
                mplier_d = b;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = RUN;
            end
            RUN: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    z_d     = sum[SIZE-1:0];
                    zh_d    = sum[2*SIZE-1:SIZE];
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d == RUN;
        done_d = state_d == DONE;
    end
    // single state register: FSM, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            z_q      <= '0;
            zh_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            z_q      <= z_d;
            zh_q     <= zh_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_y_mul_seq.sv
// tb_y_mul_seq: directed scoreboard bench for y_mul_seq (adapts to Y_MUL_EARLY_TERM_EN)
module tb_y_mul_seq;
    localparam int SIZE = 32;
    logic clk = 1'b0;
    logic rst_n, start, busy, done;
    logic [SIZE-1:0] a, b, z, zh;
    int checks = 0, passed = 0, fails = 0;
    logic [2*SIZE-1:0] sbq[$];
    logic [2*SIZE-1:0] prev;

    y_mul_seq #(.SIZE(SIZE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .z(z), .zh(zh)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2*SIZE-1:0] obs, input logic [2*SIZE-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected RUN length in edges for multiplier bv
    function automatic int run_len(input logic [SIZE-1:0] bv);
        int n = 1;
        for (int i = 0; i < SIZE; i++) if (bv[i]) n = i + 1;
`ifndef Y_MUL_EARLY_TERM_EN
        n = SIZE;
`endif
        return n;
    endfunction

    task automatic start_mul(input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv);
        a = av;
        b = bv;
        start = 1'b1;
        sbq.push_back({{SIZE{1'b0}}, av} * {{SIZE{1'b0}}, bv});
        tick();
        start = 1'b0;
    endtask

    // counts remaining busy cycles, then checks the done pulse against the scoreboard
    task automatic wait_done(input string tag, input int exp_len);
        int len = 0;
        logic [2*SIZE-1:0] e;
        while (busy && len < 4 * SIZE) begin
            if (len == 0) chk({tag, " hold"}, {zh, z}, prev);
            len++;
            tick();
        end
        chk({tag, " len"}, len, exp_len);
        chk({tag, " done"}, done, 1);
        chk({tag, " sb"}, sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, " prod"}, {zh, z}, e);
            prev = e;
        end
        tick();
        chk({tag, " pulse"}, done, 0);
        chk({tag, " idle"}, busy, 0);
    endtask

    task automatic run_mul(input string tag, input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv);
        start_mul(av, bv);
        wait_done(tag, run_len(bv));
    endtask

    initial begin
        int k, dn, cyc, t0, ndone;
        logic [2*SIZE-1:0] e;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        prev = '0;
        tick();
        tick();
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst z", z, 0);
        chk("rst zh", zh, 0);
        rst_n = 1'b1;
        tick();

        run_mul("3x5", 32'd3, 32'd5);
        run_mul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_mul("bzero", 32'h1234_5678, 32'd0);
        run_mul("azero", 32'd0, 32'h8000_0001);
        for (int i = 0; i < 3; i++) run_mul("rand", $urandom, $urandom);

        // operand change and start pulse during RUN are ignored
        start_mul(32'd7, 32'd9);
        repeat (3) tick();
        a = 32'd2;
        b = 32'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignore", run_len(32'd9) - 4);
        dn = 0;
        repeat (40) begin
            if (done || busy) dn++;
            tick();
        end
        chk("ignore extra", dn, 0);
        chk("ignore keep", {zh, z}, 64'd63);

        // reset mid-RUN aborts with no done and clears the result
        a = 32'd10;
        b = 32'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = run_len(32'd10) > 10 ? 10 : run_len(32'd10) - 1;
        repeat (k - 1) tick();
        rst_n = 1'b0;
        tick();
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort z", z, 0);
        chk("abort zh", zh, 0);
        start = 1'b1;
        tick();
        chk("rst prio", busy, 0);
        rst_n = 1'b1;
        start = 1'b0;
        prev = '0;
        dn = 0;
        repeat (5) begin
            tick();
            if (done || busy) dn++;
        end
        chk("abort nodone", dn, 0);
        run_mul("after rst", 32'd10, 32'd10);

        // start held high: one capture per IDLE visit, start during DONE ignored
        a = 32'd4;
        b = 32'd6;
        start = 1'b1;
        sbq.push_back(64'd24);
        sbq.push_back(64'd24);
        ndone = 0;
        cyc = 0;
        t0 = 0;
        while (ndone < 2 && cyc < 400) begin
            tick();
            cyc++;
            if (done) begin
                ndone++;
                e = sbq.pop_front();
                chk("held prod", {zh, z}, e);
                if (ndone == 2) chk("held gap", cyc - t0, run_len(32'd6) + 2);
                t0 = cyc;
            end
        end
        chk("held dones", ndone, 2);
        start = 1'b0;
        tick();
        tick();
        chk("held idle", busy, 0);
        chk("sb empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
